// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the MIPS-subset multicycle controller: opcodes, functs, FSM states,
// datapath select values and the one-hot instruction class.
package multicycle_controller_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpJal   = 6'h03;

    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnJr    = 6'h08;

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;

    localparam logic [1:0] A3Rd     = 2'd0;
    localparam logic [1:0] A3Rt     = 2'd1;
    localparam logic [1:0] A3Ra     = 2'd2;

    localparam logic [1:0] WdAlu    = 2'd0;
    localparam logic [1:0] WdDm     = 2'd1;
    localparam logic [1:0] WdExt    = 2'd2;
    localparam logic [1:0] WdPc4    = 2'd3;

    localparam logic [1:0] AluAdd   = 2'd0;
    localparam logic [1:0] AluSub   = 2'd1;
    localparam logic [1:0] AluOr    = 2'd2;

    localparam logic [1:0] ExtZero  = 2'd0;
    localparam logic [1:0] ExtSign  = 2'd1;
    localparam logic [1:0] ExtLui   = 2'd2;

    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic jr;
    } instr_class_t;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational opcode/funct decoder producing a one-hot instruction class;
// anything outside the supported subset is reported as illegal.
module instr_class_dec
    import multicycle_controller_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAddu:  cls.addu = 1'b1;
                    FnSubu:  cls.subu = 1'b1;
                    FnJr:    cls.jr   = 1'b1;
                    default: ;
                endcase
            end
            OpOri:   cls.ori = 1'b1;
            OpLw:    cls.lw  = 1'b1;
            OpSw:    cls.sw  = 1'b1;
            OpBeq:   cls.beq = 1'b1;
            OpLui:   cls.lui = 1'b1;
            OpJal:   cls.jal = 1'b1;
            default: ;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the shared-ALU MIPS-subset datapath,
// with a sticky illegal-encoding flag and a retired-instruction counter.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PC_WE,
    output logic             IR_WE,
    output logic             isbeq,
    output logic             isjal,
    output logic             isjr,
    output logic [1:0]       GRF_A3_MUX,
    output logic [1:0]       GRF_WD_MUX,
    output logic             GRF_WE,
    output logic             ALU_B_MUX,
    output logic [1:0]       ALUOp,
    output logic             DM_WE,
    output logic [1:0]       EXTOp,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WaitW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [2:0]       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    instr_class_t     cls;
    logic             cls_illegal;
    logic             mem_last, complete;
    logic             pc_we, ir_we, grf_we, dm_we;

    instr_class_dec u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .illegal (cls_illegal)
    );

    assign mem_last = (wait_q == WaitW'(MEM_LAT - 1));

    always_comb begin
        state_d    = StFetch;
        wait_d     = '0;
        illegal_d  = illegal_q;
        complete   = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        grf_we     = 1'b0;
        dm_we      = 1'b0;
        isbeq      = 1'b0;
        isjal      = 1'b0;
        isjr       = 1'b0;
        GRF_A3_MUX = A3Rd;
        GRF_WD_MUX = WdAlu;
        ALU_B_MUX  = 1'b0;
        ALUOp      = AluAdd;
        EXTOp      = ExtZero;

        // ALU/EXT selects stay stable from EXEC through MEM and WB
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            if (cls.subu) ALUOp = AluSub;
            if (cls.ori) begin
                ALU_B_MUX = 1'b1;
                ALUOp     = AluOr;
            end
            if (cls.lui) EXTOp = ExtLui;
            if (cls.lw || cls.sw) begin
                ALU_B_MUX = 1'b1;
                EXTOp     = ExtSign;
            end
        end

        case (state_q)
            StFetch: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (cls.jal) begin
                    pc_we      = 1'b1;
                    isjal      = 1'b1;
                    grf_we     = 1'b1;
                    GRF_A3_MUX = A3Ra;
                    GRF_WD_MUX = WdPc4;
                    complete   = 1'b1;
                end else if (cls.jr) begin
                    pc_we    = 1'b1;
                    isjr     = 1'b1;
                    complete = 1'b1;
                end else if (cls_illegal) begin
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cls.beq) begin
                    ALUOp    = AluSub;
                    isbeq    = 1'b1;
                    pc_we    = zero;
                    complete = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    state_d = StMem;
                end else if (cls.addu || cls.subu || cls.ori || cls.lui) begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (!mem_last) begin
                    state_d = StMem;
                    wait_d  = wait_q + WaitW'(1);
                end else if (cls.lw) begin
                    state_d = StWb;
                end else if (cls.sw) begin
                    dm_we    = 1'b1;
                    complete = 1'b1;
                end
            end
            StWb: begin
                grf_we   = 1'b1;
                complete = 1'b1;
                if (cls.ori || cls.lw || cls.lui) GRF_A3_MUX = A3Rt;
                if (cls.lw)  GRF_WD_MUX = WdDm;
                if (cls.lui) GRF_WD_MUX = WdExt;
            end
            default: state_d = StFetch;
        endcase

        retired_d = complete ? retired_q + CNT_W'(1) : retired_q;
    end

    assign PC_WE   = pc_we  & reset_n;
    assign IR_WE   = ir_we  & reset_n;
    assign GRF_WE  = grf_we & reset_n;
    assign DM_WE   = dm_we  & reset_n;
    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

endmodule
